// File: rtl/fpu_writeback_stage_if.sv
// Handshake/bus bundle between the EX/ID stages, the FPU writeback buffer and the register-file write port.
interface fpu_writeback_stage_if #(
    parameter int DATA_W = 32
);
    logic              fpu_sel;
    logic [3:0]        fpuOp;
    logic              fpu_inprogress;
    logic [4:0]        rd_in;
    logic [DATA_W-1:0] fpu_result;
    logic [4:0]        fflags_in;
    logic              flush;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        id_rs3;
    logic [2:0]        id_rs_fp;
    logic              wb_ready;
    logic              fflags_clr;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              wb_to_int;
    logic [4:0]        fflags_acc;
    logic              hazard_stall;
    logic              fpu_hold;

    modport master (
        output fpu_sel, fpuOp, fpu_inprogress, rd_in, fpu_result, fflags_in, flush,
               id_rs1, id_rs2, id_rs3, id_rs_fp, wb_ready, fflags_clr,
        input  wb_valid, wb_rd, wb_data, wb_to_int, fflags_acc, hazard_stall, fpu_hold
    );

    modport slave (
        input  fpu_sel, fpuOp, fpu_inprogress, rd_in, fpu_result, fflags_in, flush,
               id_rs1, id_rs2, id_rs3, id_rs_fp, wb_ready, fflags_clr,
        output wb_valid, wb_rd, wb_data, wb_to_int, fflags_acc, hazard_stall, fpu_hold
    );
endinterface

// File: rtl/fpu_writeback_stage.sv
// FPU writeback stage: captures completed FPU results into a 2-entry in-order buffer, drains them to the
// FP/integer register file, flags RAW hazards against in-flight destinations and accumulates fcsr flags.
module fpu_writeback_stage #(
    parameter int          DATA_W        = 32,
    parameter logic [15:0] INT_DEST_MASK = 16'h00A0
) (
    input  logic                 clock,
    input  logic                 clear,
    fpu_writeback_stage_if.slave wb_bus
);
    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    typedef struct packed {
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
        logic [4:0]        flags;
        logic              to_int;
    } entry_t;

    // An integer-file rd of x0 is never a real dependency.
    function automatic logic rs_hit(input logic [4:0] rs, input logic rs_fp,
                                    input logic [4:0] rd, input logic to_int);
        return (rs == rd) && (rs_fp != to_int) && !(to_int && (rd == 5'd0));
    endfunction

    function automatic logic dest_hit(input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [4:0] rs3, input logic [2:0] fp,
                                      input logic [4:0] rd, input logic to_int);
        return rs_hit(rs1, fp[0], rd, to_int) | rs_hit(rs2, fp[1], rd, to_int) |
               rs_hit(rs3, fp[2], rd, to_int);
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic        latch_s;
    logic [4:0]  busy_rd_r;
    logic        busy_int_r;
    logic [1:0]  count_r;
    entry_t      head_r;
    entry_t      tail_r;
    logic [4:0]  fflags_acc_r;
    logic        fpu_hold_s;
    logic        push_s;
    logic        pop_s;
    logic        hazard_s;
    entry_t      new_entry_s;

    // Hold, handshake qualifiers and the entry that a completion would push.
    always_comb begin
        fpu_hold_s  = (count_r == 2'd2) | ((count_r == 2'd1) & ~wb_bus.wb_ready);
        push_s      = wb_bus.fpu_sel & ~wb_bus.fpu_inprogress & ~wb_bus.flush & ~fpu_hold_s;
        pop_s       = (count_r != 2'd0) & wb_bus.wb_ready;
        new_entry_s = '{rd: wb_bus.rd_in, data: wb_bus.fpu_result, flags: wb_bus.fflags_in,
                        to_int: INT_DEST_MASK[wb_bus.fpuOp]};
    end

    // Next-state logic for the in-flight op tracker.
    always_comb begin
        state_s = state_r;
        latch_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (wb_bus.fpu_sel & wb_bus.fpu_inprogress & ~wb_bus.flush) begin
                    state_s = BUSY;
                    latch_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (push_s | wb_bus.flush) begin
                    state_s = IDLE;
                end else begin
                    state_s = BUSY;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register and latched in-flight destination.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_r    <= IDLE;
            busy_rd_r  <= 5'd0;
            busy_int_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (latch_s) begin
                busy_rd_r  <= wb_bus.rd_in;
                busy_int_r <= INT_DEST_MASK[wb_bus.fpuOp];
            end
        end
    end

    // Two-entry FIFO kept as a shift pair so the head is always the register driving wb_*.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            count_r <= 2'd0;
            head_r  <= '0;
            tail_r  <= '0;
        end else begin
            case ({push_s, pop_s})
                2'b11: begin
                    if (count_r == 2'd1) begin
                        head_r <= new_entry_s;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= new_entry_s;
                    end
                end
                2'b01: begin
                    head_r  <= tail_r;
                    count_r <= count_r - 2'd1;
                end
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_r <= new_entry_s;
                    end else begin
                        tail_r <= new_entry_s;
                    end
                    count_r <= count_r + 2'd1;
                end
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky flags: a clear coinciding with a pop keeps only the popped entry's flags.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            fflags_acc_r <= 5'd0;
        end else if (pop_s) begin
            fflags_acc_r <= wb_bus.fflags_clr ? head_r.flags : (fflags_acc_r | head_r.flags);
        end else if (wb_bus.fflags_clr) begin
            fflags_acc_r <= 5'd0;
        end
    end

    // RAW hazard against the in-flight op and every buffered entry.
    always_comb begin
        hazard_s =
            ((state_r == BUSY) & dest_hit(wb_bus.id_rs1, wb_bus.id_rs2, wb_bus.id_rs3,
                                          wb_bus.id_rs_fp, busy_rd_r, busy_int_r)) |
            ((count_r != 2'd0) & dest_hit(wb_bus.id_rs1, wb_bus.id_rs2, wb_bus.id_rs3,
                                          wb_bus.id_rs_fp, head_r.rd, head_r.to_int)) |
            ((count_r == 2'd2) & dest_hit(wb_bus.id_rs1, wb_bus.id_rs2, wb_bus.id_rs3,
                                          wb_bus.id_rs_fp, tail_r.rd, tail_r.to_int));
    end

    assign wb_bus.wb_valid     = (count_r != 2'd0);
    assign wb_bus.wb_rd        = head_r.rd;
    assign wb_bus.wb_data      = head_r.data;
    assign wb_bus.wb_to_int    = head_r.to_int;
    assign wb_bus.fflags_acc   = fflags_acc_r;
    assign wb_bus.hazard_stall = hazard_s;
    assign wb_bus.fpu_hold     = fpu_hold_s;
endmodule
